pipelined_control_unit: RTL and testbench

Parametrised control unit for the 5-stage pipelined RV32I core. It decodes the instruction held in the IF/ID register and carries the resulting control word through the E, M and W pipeline registers, with stall, flush and bubble support. It resolves conditional branches and jumps in E from ALU flags, and optionally decodes the M extension. It replaces the single-cycle combinational decoder and sits between the IF/ID register and the datapath and hazard unit.

---
 rtl/rv_ctrl_pkg.sv | 98 +++++++++
 rtl/control_decode.sv | 107 ++++++++++
 rtl/pipelined_control_unit.sv | 102 ++++++++++
 tb/tb_pipelined_control_unit.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/rv_ctrl_pkg.sv
// Opcodes, control-code values and pipeline control-word types shared by the RV32I control unit.
package rv_ctrl_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_SUB  = 5'b00001;
  localparam logic [4:0] ALU_XOR  = 5'b00010;
  localparam logic [4:0] ALU_OR   = 5'b00011;
  localparam logic [4:0] ALU_AND  = 5'b00100;
  localparam logic [4:0] ALU_SLL  = 5'b00101;
  localparam logic [4:0] ALU_SRL  = 5'b00110;
  localparam logic [4:0] ALU_SRA  = 5'b00111;
  localparam logic [4:0] ALU_SLT  = 5'b01000;
  localparam logic [4:0] ALU_SLTU = 5'b01001;

  localparam logic [2:0] BR_NONE = 3'b000;
  localparam logic [2:0] BR_BEQ  = 3'b001;
  localparam logic [2:0] BR_BNE  = 3'b010;
  localparam logic [2:0] BR_BLT  = 3'b011;
  localparam logic [2:0] BR_BGE  = 3'b100;
  localparam logic [2:0] BR_BLTU = 3'b101;
  localparam logic [2:0] BR_BGEU = 3'b110;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       alu_src;
    logic       jump;
    logic       jalr;
    logic       illegal;
    logic [1:0] result_src;
    logic [2:0] branch;
    logic [4:0] alu_ctrl;
  } ctrl_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic [1:0] result_src;
  } ctrl_m_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
  } ctrl_w_t;

  // RV32I base ALU op for OP/OP-IMM; alt selects SUB/SRA (funct7 bit 5).
  function automatic logic [4:0] alu_base(input logic [2:0] funct3, input logic alt);
    logic [4:0] code;
    case (funct3)
      3'b000:  code = alt ? ALU_SUB : ALU_ADD;
      3'b001:  code = ALU_SLL;
      3'b010:  code = ALU_SLT;
      3'b011:  code = ALU_SLTU;
      3'b100:  code = ALU_XOR;
      3'b101:  code = alt ? ALU_SRA : ALU_SRL;
      3'b110:  code = ALU_OR;
      default: code = ALU_AND;
    endcase
    return code;
  endfunction

  function automatic logic branch_taken(input logic [2:0] br, input logic zero,
                                        input logic lt, input logic ltu);
    logic taken;
    case (br)
      BR_BEQ:  taken = zero;
      BR_BNE:  taken = ~zero;
      BR_BLT:  taken = lt;
      BR_BGE:  taken = ~lt;
      BR_BLTU: taken = ltu;
      BR_BGEU: taken = ~ltu;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/control_decode.sv
// Combinational D-stage decoder: instruction word to control word, immediate select and illegal flag.
module control_decode
  import rv_ctrl_pkg::*;
#(
  parameter int M_EXT = 0
) (
  input  logic [31:0] instr_i,
  output ctrl_t       ctrl_o,
  output logic [2:0]  imm_src_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       illegal;
  ctrl_t      dec;
  logic       unused_fields;

  assign opcode        = instr_i[6:0];
  assign funct3        = instr_i[14:12];
  assign funct7        = instr_i[31:25];
  assign unused_fields = ^{instr_i[24:15], instr_i[11:7]};

  always_comb begin
    dec       = '0;
    imm_src_o = IMM_I;
    illegal   = 1'b0;
    case (opcode)
      OPC_LOAD: begin
        dec.reg_write  = 1'b1;
        dec.alu_src    = 1'b1;
        dec.result_src = RES_MEM;
      end
      OPC_STORE: begin
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
        imm_src_o     = IMM_S;
      end
      OPC_BRANCH: begin
        imm_src_o    = IMM_B;
        dec.alu_ctrl = ALU_SUB;
        case (funct3)
          3'b000:  dec.branch = BR_BEQ;
          3'b001:  dec.branch = BR_BNE;
          3'b100:  dec.branch = BR_BLT;
          3'b101:  dec.branch = BR_BGE;
          3'b110:  dec.branch = BR_BLTU;
          3'b111:  dec.branch = BR_BGEU;
          default: dec.branch = BR_NONE;
        endcase
      end
      OPC_JAL: begin
        dec.reg_write  = 1'b1;
        dec.jump       = 1'b1;
        dec.result_src = RES_PC4;
        imm_src_o      = IMM_J;
      end
      OPC_JALR: begin
        dec.reg_write  = 1'b1;
        dec.jump       = 1'b1;
        dec.jalr       = 1'b1;
        dec.alu_src    = 1'b1;
        dec.result_src = RES_PC4;
      end
      OPC_LUI, OPC_AUIPC: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        imm_src_o     = IMM_U;
      end
      OPC_OPIMM: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        // Only the shift forms carry a funct7 field; the rest use those bits as immediate.
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          if (funct7 != 7'b0000000 && funct7 != 7'b0100000) illegal = 1'b1;
          dec.alu_ctrl = alu_base(funct3, (funct3 == 3'b101) && funct7[5]);
        end else begin
          dec.alu_ctrl = alu_base(funct3, 1'b0);
        end
      end
      OPC_OP: begin
        dec.reg_write = 1'b1;
        case (funct7)
          7'b0000000: dec.alu_ctrl = alu_base(funct3, 1'b0);
          7'b0100000: begin
            if (funct3 == 3'b000 || funct3 == 3'b101) dec.alu_ctrl = alu_base(funct3, 1'b1);
            else illegal = 1'b1;
          end
          7'b0000001: begin
            if (M_EXT != 0) dec.alu_ctrl = {2'b10, funct3};
            else illegal = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
      end
      OPC_SYSTEM: dec = '0;
      default:    illegal = 1'b1;
    endcase
    if (illegal) begin
      dec         = '0;
      dec.illegal = 1'b1;
    end
  end

  assign ctrl_o = dec;

endmodule

// File: rtl/pipelined_control_unit.sv
// Decodes the IF/ID instruction and carries its control word through the E, M and W registers.
// E/M/W controls follow D by 1/2/3 cycles; PCSrcE resolves combinationally from E and the ALU flags.
module pipelined_control_unit
  import rv_ctrl_pkg::*;
#(
  parameter  int M_EXT  = 0,
  localparam int ALUC_W = (M_EXT != 0) ? 5 : 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       InstrD,
  input  logic              StallE,
  input  logic              FlushE,
  input  logic              ZeroE,
  input  logic              LtE,
  input  logic              LtuE,
  output logic [2:0]        ImmSrcD,
  output logic              RegWriteE,
  output logic              MemWriteE,
  output logic              ALUSrcE,
  output logic              JumpE,
  output logic              JalrE,
  output logic              IllegalE,
  output logic [1:0]        ResultSrcE,
  output logic [2:0]        BranchE,
  output logic [ALUC_W-1:0] ALUControlE,
  output logic              PCSrcE,
  output logic              RegWriteM,
  output logic              MemWriteM,
  output logic              RegWriteW,
  output logic [1:0]        ResultSrcM,
  output logic [1:0]        ResultSrcW
);

  ctrl_t   ctrl_d;
  ctrl_t   ctrl_e_d, ctrl_e_q;
  ctrl_m_t ctrl_m_d, ctrl_m_q;
  ctrl_w_t ctrl_w_d, ctrl_w_q;
  logic    e_hold;
  logic    unused_alu_msb;

  control_decode #(.M_EXT(M_EXT)) u_decode (
    .instr_i   (InstrD),
    .ctrl_o    (ctrl_d),
    .imm_src_o (ImmSrcD)
  );

  assign e_hold = StallE & ~FlushE;

  always_comb begin
    ctrl_e_d = ctrl_e_q;
    if (FlushE) ctrl_e_d = '0;
    else if (!StallE) ctrl_e_d = ctrl_d;
  end

  // A held E word must reach M only once, so M takes a bubble while E is holding.
  always_comb begin
    ctrl_m_d = '0;
    if (!e_hold) begin
      ctrl_m_d.reg_write  = ctrl_e_q.reg_write;
      ctrl_m_d.mem_write  = ctrl_e_q.mem_write;
      ctrl_m_d.result_src = ctrl_e_q.result_src;
    end
  end

  always_comb begin
    ctrl_w_d.reg_write  = ctrl_m_q.reg_write;
    ctrl_w_d.result_src = ctrl_m_q.result_src;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_e_q <= '0;
      ctrl_m_q <= '0;
      ctrl_w_q <= '0;
    end else begin
      ctrl_e_q <= ctrl_e_d;
      ctrl_m_q <= ctrl_m_d;
      ctrl_w_q <= ctrl_w_d;
    end
  end

  assign RegWriteE      = ctrl_e_q.reg_write;
  assign MemWriteE      = ctrl_e_q.mem_write;
  assign ALUSrcE        = ctrl_e_q.alu_src;
  assign JumpE          = ctrl_e_q.jump;
  assign JalrE          = ctrl_e_q.jalr;
  assign IllegalE       = ctrl_e_q.illegal;
  assign ResultSrcE     = ctrl_e_q.result_src;
  assign BranchE        = ctrl_e_q.branch;
  assign ALUControlE    = ctrl_e_q.alu_ctrl[ALUC_W-1:0];
  assign unused_alu_msb = ctrl_e_q.alu_ctrl[4];

  assign PCSrcE = ctrl_e_q.jump | branch_taken(ctrl_e_q.branch, ZeroE, LtE, LtuE);

  assign RegWriteM  = ctrl_m_q.reg_write;
  assign MemWriteM  = ctrl_m_q.mem_write;
  assign ResultSrcM = ctrl_m_q.result_src;
  assign RegWriteW  = ctrl_w_q.reg_write;
  assign ResultSrcW = ctrl_w_q.result_src;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Table-driven check of decode/E-stage controls for M_EXT=0 and 1, plus stall, flush and reset sequences.
module tb_pipelined_control_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] InstrD;
  logic        StallE, FlushE, ZeroE, LtE, LtuE;

  logic [2:0] ImmSrcD1, BranchE1, ImmSrcD0, BranchE0;
  logic [1:0] ResultSrcE1, ResultSrcM1, ResultSrcW1, ResultSrcE0, ResultSrcM0, ResultSrcW0;
  logic [4:0] ALUControlE1;
  logic [3:0] ALUControlE0;
  logic RegWriteE1, MemWriteE1, ALUSrcE1, JumpE1, JalrE1, IllegalE1, PCSrcE1;
  logic RegWriteM1, MemWriteM1, RegWriteW1;
  logic RegWriteE0, MemWriteE0, ALUSrcE0, JumpE0, JalrE0, IllegalE0, PCSrcE0;
  logic RegWriteM0, MemWriteM0, RegWriteW0;

  always #5 clk = ~clk;

  pipelined_control_unit #(.M_EXT(1)) u_m1 (
    .clk(clk), .rst(rst), .InstrD(InstrD), .StallE(StallE), .FlushE(FlushE),
    .ZeroE(ZeroE), .LtE(LtE), .LtuE(LtuE), .ImmSrcD(ImmSrcD1),
    .RegWriteE(RegWriteE1), .MemWriteE(MemWriteE1), .ALUSrcE(ALUSrcE1), .JumpE(JumpE1),
    .JalrE(JalrE1), .IllegalE(IllegalE1), .ResultSrcE(ResultSrcE1), .BranchE(BranchE1),
    .ALUControlE(ALUControlE1), .PCSrcE(PCSrcE1), .RegWriteM(RegWriteM1),
    .MemWriteM(MemWriteM1), .RegWriteW(RegWriteW1), .ResultSrcM(ResultSrcM1),
    .ResultSrcW(ResultSrcW1)
  );

  pipelined_control_unit #(.M_EXT(0)) u_m0 (
    .clk(clk), .rst(rst), .InstrD(InstrD), .StallE(StallE), .FlushE(FlushE),
    .ZeroE(ZeroE), .LtE(LtE), .LtuE(LtuE), .ImmSrcD(ImmSrcD0),
    .RegWriteE(RegWriteE0), .MemWriteE(MemWriteE0), .ALUSrcE(ALUSrcE0), .JumpE(JumpE0),
    .JalrE(JalrE0), .IllegalE(IllegalE0), .ResultSrcE(ResultSrcE0), .BranchE(BranchE0),
    .ALUControlE(ALUControlE0), .PCSrcE(PCSrcE0), .RegWriteM(RegWriteM0),
    .MemWriteM(MemWriteM0), .RegWriteW(RegWriteW0), .ResultSrcM(ResultSrcM0),
    .ResultSrcW(ResultSrcW0)
  );

  // E word layout: {RegWrite, MemWrite, ALUSrc, Jump, Jalr, Illegal, ResultSrc, Branch, ALUControl, PCSrc}
  logic [16:0] act1, act0;
  logic [5:0]  late1;
  assign act1  = {RegWriteE1, MemWriteE1, ALUSrcE1, JumpE1, JalrE1, IllegalE1, ResultSrcE1,
                  BranchE1, ALUControlE1, PCSrcE1};
  assign act0  = {RegWriteE0, MemWriteE0, ALUSrcE0, JumpE0, JalrE0, IllegalE0, ResultSrcE0,
                  BranchE0, 1'b0, ALUControlE0, PCSrcE0};
  assign late1 = {RegWriteM1, MemWriteM1, ResultSrcM1, RegWriteW1, ResultSrcW1};

  typedef struct packed {
    logic [31:0] instr;
    logic [2:0]  flg;   // {Zero, Lt, Ltu}
    logic [2:0]  imm;
    logic [5:0]  ctl;   // {RegWrite, MemWrite, ALUSrc, Jump, Jalr, Illegal}
    logic [1:0]  rs;
    logic [2:0]  br;
    logic [4:0]  alu;
    logic        pc;
    logic        mext;
  } vec_t;

  localparam int NV = 20;
  localparam logic [31:0] I_ADD = 32'h002081B3, I_SUB = 32'h402081B3, I_LW = 32'h0000A183;
  localparam logic [31:0] I_NOP = 32'h00000073, I_BAD = 32'h0000007F;

  vec_t vecs [NV];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  initial begin
    logic [16:0] exp1, exp0;
    vecs[0]  = '{I_ADD,        3'b000, 3'b000, 6'b100000, 2'b00, 3'b000, 5'b00000, 1'b0, 1'b0};
    vecs[1]  = '{I_SUB,        3'b000, 3'b000, 6'b100000, 2'b00, 3'b000, 5'b00001, 1'b0, 1'b0};
    vecs[2]  = '{32'h00208463, 3'b100, 3'b010, 6'b000000, 2'b00, 3'b001, 5'b00001, 1'b1, 1'b0};
    vecs[3]  = '{32'h00208463, 3'b000, 3'b010, 6'b000000, 2'b00, 3'b001, 5'b00001, 1'b0, 1'b0};
    vecs[4]  = '{32'h00209463, 3'b100, 3'b010, 6'b000000, 2'b00, 3'b010, 5'b00001, 1'b0, 1'b0};
    vecs[5]  = '{32'h0020C463, 3'b010, 3'b010, 6'b000000, 2'b00, 3'b011, 5'b00001, 1'b1, 1'b0};
    vecs[6]  = '{32'h0020F463, 3'b001, 3'b010, 6'b000000, 2'b00, 3'b110, 5'b00001, 1'b0, 1'b0};
    vecs[7]  = '{I_LW,         3'b000, 3'b000, 6'b101000, 2'b01, 3'b000, 5'b00000, 1'b0, 1'b0};
    vecs[8]  = '{32'h0020A223, 3'b000, 3'b001, 6'b011000, 2'b00, 3'b000, 5'b00000, 1'b0, 1'b0};
    vecs[9]  = '{32'h008000EF, 3'b000, 3'b100, 6'b100100, 2'b10, 3'b000, 5'b00000, 1'b1, 1'b0};
    vecs[10] = '{32'h000080E7, 3'b000, 3'b000, 6'b101110, 2'b10, 3'b000, 5'b00000, 1'b1, 1'b0};
    vecs[11] = '{32'h123450B7, 3'b000, 3'b011, 6'b101000, 2'b00, 3'b000, 5'b00000, 1'b0, 1'b0};
    vecs[12] = '{32'h4030D093, 3'b000, 3'b000, 6'b101000, 2'b00, 3'b000, 5'b00111, 1'b0, 1'b0};
    vecs[13] = '{32'h0200D093, 3'b000, 3'b000, 6'b000001, 2'b00, 3'b000, 5'b00000, 1'b0, 1'b0};
    vecs[14] = '{32'h0020B1B3, 3'b000, 3'b000, 6'b100000, 2'b00, 3'b000, 5'b01001, 1'b0, 1'b0};
    vecs[15] = '{32'h4020C1B3, 3'b000, 3'b000, 6'b000001, 2'b00, 3'b000, 5'b00000, 1'b0, 1'b0};
    vecs[16] = '{I_BAD,        3'b000, 3'b000, 6'b000001, 2'b00, 3'b000, 5'b00000, 1'b0, 1'b0};
    vecs[17] = '{I_NOP,        3'b000, 3'b000, 6'b000000, 2'b00, 3'b000, 5'b00000, 1'b0, 1'b0};
    vecs[18] = '{32'h022081B3, 3'b100, 3'b000, 6'b100000, 2'b00, 3'b000, 5'b10000, 1'b0, 1'b1};
    vecs[19] = '{32'h0220C1B3, 3'b000, 3'b000, 6'b100000, 2'b00, 3'b000, 5'b10100, 1'b0, 1'b1};

    rst = 1'b0; InstrD = I_ADD; StallE = 1'b0; FlushE = 1'b0;
    ZeroE = 1'b0; LtE = 1'b0; LtuE = 1'b0;

    // Reset state, held through a clock edge, and still clear just after release.
    #2;
    check("reset_e_m1", 32'(act1), 32'd0);
    check("reset_e_m0", 32'(act0), 32'd0);
    check("reset_mw_m1", 32'(late1), 32'd0);
    @(posedge clk); #1;
    check("reset_held_e_m1", 32'(act1), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("post_release_e_m1", 32'(act1), 32'd0);
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      InstrD = vecs[i].instr;
      {ZeroE, LtE, LtuE} = vecs[i].flg;
      exp1 = {vecs[i].ctl, vecs[i].rs, vecs[i].br, vecs[i].alu, vecs[i].pc};
      exp0 = vecs[i].mext ? {6'b000001, 2'b00, 3'b000, 5'b00000, 1'b0} : exp1;
      #1;
      check($sformatf("vec%0d_imm", i), 32'(ImmSrcD1), 32'(vecs[i].imm));
      @(posedge clk); #1;
      check($sformatf("vec%0d_e_m1", i), 32'(act1), 32'(exp1));
      check($sformatf("vec%0d_e_m0", i), 32'(act0), 32'(exp0));
      @(negedge clk);
    end
    {ZeroE, LtE, LtuE} = 3'b000;

    // add, sub back to back through E, M and W.
    InstrD = I_NOP;
    repeat (3) @(posedge clk);
    @(negedge clk); InstrD = I_ADD;
    @(posedge clk); #1;
    check("as_add_aluc_e", 32'(ALUControlE1), 32'h0);
    check("as_add_rw_e", 32'(RegWriteE1), 32'd1);
    check("as_add_rw_m", 32'(RegWriteM1), 32'd0);
    @(negedge clk); InstrD = I_SUB;
    @(posedge clk); #1;
    check("as_sub_aluc_e", 32'(ALUControlE1), 32'h1);
    check("as_sub_rw_e", 32'(RegWriteE1), 32'd1);
    check("as_add_rw_m1", 32'(RegWriteM1), 32'd1);
    check("as_rw_w_early", 32'(RegWriteW1), 32'd0);
    @(negedge clk); InstrD = I_NOP;
    @(posedge clk); #1;
    check("as_nop_rw_e", 32'(RegWriteE1), 32'd0);
    check("as_sub_rw_m", 32'(RegWriteM1), 32'd1);
    check("as_add_rw_w", 32'(RegWriteW1), 32'd1);
    @(posedge clk); #1;
    check("as_nop_rw_m", 32'(RegWriteM1), 32'd0);
    check("as_sub_rw_w", 32'(RegWriteW1), 32'd1);

    // lw held in E for two cycles reaches M exactly once.
    @(negedge clk); InstrD = I_LW;
    @(posedge clk); #1;
    check("st_lw_rs_e", 32'(ResultSrcE1), 32'd1);
    @(negedge clk); InstrD = I_NOP; StallE = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      check($sformatf("st_hold%0d_rs_e", c), 32'(ResultSrcE1), 32'd1);
      check($sformatf("st_hold%0d_rs_m", c), 32'(ResultSrcM1), 32'd0);
    end
    @(negedge clk); StallE = 1'b0;
    @(posedge clk); #1;
    check("st_rel_rs_e", 32'(ResultSrcE1), 32'd0);
    check("st_rel_rs_m", 32'(ResultSrcM1), 32'd1);
    @(posedge clk); #1;
    check("st_rel2_rs_m", 32'(ResultSrcM1), 32'd0);
    check("st_rel2_rs_w", 32'(ResultSrcW1), 32'd1);

    // Flush with stall: E becomes a bubble even for an illegal D word; lw moves on to M.
    @(negedge clk); InstrD = I_LW;
    @(posedge clk); #1;
    @(negedge clk); InstrD = I_BAD; StallE = 1'b1; FlushE = 1'b1;
    @(posedge clk); #1;
    check("fs_bubble_e_m1", 32'(act1), 32'd0);
    check("fs_bubble_e_m0", 32'(act0), 32'd0);
    check("fs_lw_rs_m", 32'(ResultSrcM1), 32'd1);
    @(negedge clk); StallE = 1'b0; FlushE = 1'b0; InstrD = I_NOP;

    // Asynchronous reset between clock edges while RegWriteM is set.
    @(negedge clk); InstrD = I_ADD;
    @(posedge clk);
    @(posedge clk); #1;
    check("ar_pre_rw_m", 32'(RegWriteM1), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("ar_e_m1", 32'(act1), 32'd0);
    check("ar_mw_m1", 32'(late1), 32'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("ar_resume_rw_e", 32'(RegWriteE1), 32'd1);
    check("ar_resume_rw_m", 32'(RegWriteM1), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
